nios2_oci_dct_packer: RTL and testbench
=======================================

Name: nios2_oci_dct_packer

Overview:
Producer side of the OCI data-compression-trace (DCT) frame interface. It packs 2-bit trace atoms into a 30-bit frame, `dct_buffer`, with an atom count, `dct_count`. Frames go out over a valid/ready handshake to the trace sink or test-bench monitor. It also drives the end-of-test handshake: `test_ending` flushes the partial frame, and `test_has_ended` reports that draining is complete.

Parameters:
- ATOM_W, 2, bits per trace atom
- DEPTH, 15, atoms per full frame
- CNT_W, 4, width of dct_count; must satisfy 2**CNT_W > DEPTH
- Derived localparam BUF_W = ATOM_W*DEPTH = 30.

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- atom_valid  in  1  upstream atom present
- atom_data  in  ATOM_W  atom value
- atom_ready  out  1  packer accepts an atom this cycle
- test_ending  in  1  request to flush and end; level or pulse, latched
- frame_valid  out  1  dct_buffer/dct_count hold a frame
- frame_ready  in  1  sink accepts the frame
- dct_buffer  out  BUF_W  packed atoms; oldest atom in the most significant occupied slot
- dct_count  out  CNT_W  number of valid atoms in the frame (1..DEPTH)
- test_has_ended  out  1  all atoms delivered; terminal
- drop_count  out  16  dropped-atom counter (see Optional Feature)

Behaviour:
- Reset values: state=FILL, dct_buffer=0, dct_count=0, frame_valid=0, test_has_ended=0, flush_pending=0, drop_count=0. atom_ready=1 from the cycle after reset deasserts.
- Reset asserted in any state discards any partial or unsent frame. There is no output during reset.
- States: FILL, EMIT, DONE.
- FILL:
  - atom_ready=1.
  - On an accept (atom_valid & atom_ready): dct_buffer <= {dct_buffer[BUF_W-ATOM_W-1:0], atom_data}, and dct_count <= dct_count+1.
  - If the accept makes dct_count reach DEPTH, go to EMIT on the next edge.
  - test_ending sets flush_pending.
    - If flush_pending is set, or test_ending is high this cycle, and the count after any same-cycle accept is >0, go to EMIT.
    - If that count is 0, go to DONE.
  - A same-cycle accept and test_ending: the atom is included in the flushed frame.
- EMIT:
  - frame_valid=1 and atom_ready=0.
  - dct_buffer and dct_count are held stable until frame_ready.
  - test_ending during EMIT sets flush_pending.
  - On frame_ready: clear dct_buffer and dct_count. Go to DONE if flush_pending, else go to FILL.
  - frame_valid deasserts on the edge after the handshake.
- DONE: test_has_ended=1, atom_ready=0, frame_valid=0. The block stays in DONE until reset.
- Latency:
  - frame_valid rises one cycle after the accept that completes a frame, or after test_ending with a partial frame.
  - Best-case throughput is 15 atoms per 16 cycles (one bubble cycle per frame).
- Partial frames are right-justified: unused upper slots read 0.

Optional Feature:
- Macro NIOS2_OCI_DCT_DROP_EN. It models a CPU trace port, which cannot stall.
- With the macro:
  - atom_ready is tied to 1.
  - Atoms presented while not in FILL are discarded.
  - drop_count increments once per discarded atom and saturates at 16'hFFFF.
  - drop_count clears on reset.
- Without the macro:
  - Full backpressure applies as specified above.
  - drop_count is tied to 0 and the saturating counter is not instantiated.

Decomposition:
- Package nios2_oci_dct_pkg holds: ATOM_W, DEPTH, CNT_W, BUF_W; the state enum dct_state_t {FILL, EMIT, DONE}; and atom code constants (2'b00 NOP, 2'b01 TAKEN, 2'b10 NOT_TAKEN, 2'b11 INDIRECT).
- One sub-module, nios2_oci_sat_counter: a 16-bit saturating counter with clear and increment inputs. It is instantiated only under NIOS2_OCI_DCT_DROP_EN.

Test Plan:
- 15 atoms back-to-back, all 2'b01, frame_ready=1:
  - frame_valid for 1 cycle with dct_buffer=30'h15555555 and dct_count=15.
  - atom_ready=0 for exactly 1 cycle.
- Atoms 2'b11, 2'b10, 2'b01, then test_ending:
  - one frame with dct_buffer=30'h39 and dct_count=3.
  - test_has_ended=1 one cycle after the handshake.
- Full frame pending with frame_ready=0 for 5 cycles and atom_valid held:
  - dct_buffer and dct_count stable.
  - atom_ready=0 and no atoms lost.
  - Accepts resume after the handshake with dct_count restarting at 1.
- test_ending on the same cycle as the 15th accept:
  - full frame (dct_count=15) emitted, then DONE.
  - No empty frame emitted.
- test_ending with dct_count=0: no frame_valid, and test_has_ended=1 on the next cycle.
- reset asserted mid-FILL with dct_count=7:
  - next cycle dct_count=0, frame_valid=0, test_has_ended=0.
- With NIOS2_OCI_DCT_DROP_EN: 20 atoms streamed with frame_ready=0 gives 15 packed and drop_count=5.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants, state encoding and atom codes for the OCI DCT frame packer.
package nios2_oci_dct_pkg;

  localparam int unsigned ATOM_W = 2;
  localparam int unsigned DEPTH  = 15;
  // dct_count must be able to hold DEPTH: 2**CNT_W > DEPTH.
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BUF_W  = ATOM_W * DEPTH;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    DONE
  } dct_state_t;

  localparam logic [ATOM_W-1:0] ATOM_NOP       = 2'b00;
  localparam logic [ATOM_W-1:0] ATOM_TAKEN     = 2'b01;
  localparam logic [ATOM_W-1:0] ATOM_NOT_TAKEN = 2'b10;
  localparam logic [ATOM_W-1:0] ATOM_INDIRECT  = 2'b11;

endpackage

// File: rtl/nios2_oci_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module nios2_oci_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             incr,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (incr && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT frames with valid/ready output and end-of-test flush.
// Optional NIOS2_OCI_DCT_DROP_EN: never stall upstream; count atoms discarded outside FILL.
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic              atom_ready,
  input  logic              test_ending,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_has_ended,
  output logic [15:0]       drop_count
);

  dct_state_t       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;

  logic             in_fill;
  logic             accept;
  logic             flush_req;
  logic [CNT_W-1:0] cnt_inc;

  assign in_fill   = (state_q == FILL);
  assign accept    = atom_valid & in_fill;
  assign flush_req = flush_q | test_ending;
  assign cnt_inc   = cnt_q + CNT_W'(accept);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    flush_d = flush_req;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          buf_d = {buf_q[BUF_W-ATOM_W-1:0], atom_data};
          cnt_d = cnt_inc;
        end
        // A same-cycle accept is counted before deciding whether a flush has anything to send.
        if (cnt_inc == CNT_W'(DEPTH)) begin
          state_d = EMIT;
        end else if (flush_req) begin
          state_d = (cnt_inc != '0) ? EMIT : DONE;
        end
      end
      EMIT: begin
        if (frame_ready) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = flush_req ? DONE : FILL;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign frame_valid    = (state_q == EMIT) & ~reset;
  assign test_has_ended = (state_q == DONE) & ~reset;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;

`ifdef NIOS2_OCI_DCT_DROP_EN
  logic drop_incr;

  assign atom_ready = 1'b1;
  assign drop_incr  = atom_valid & ~in_fill & ~reset;

  nios2_oci_sat_counter #(
    .Width(16)
  ) u_drop_counter (
    .clk  (clk),
    .clear(reset),
    .incr (drop_incr),
    .count(drop_count)
  );
`else
  assign atom_ready = in_fill & ~reset;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Randomized and directed bench for nios2_oci_dct_packer with a frame-level scoreboard.
module tb_nios2_oci_dct_packer;
  import nios2_oci_dct_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              atom_valid;
  logic [ATOM_W-1:0] atom_data;
  logic              atom_ready;
  logic              test_ending;
  logic              frame_valid;
  logic              frame_ready;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_has_ended;
  logic [15:0]       drop_count;

  nios2_oci_dct_packer dut (
    .clk           (clk),
    .reset         (reset),
    .atom_valid    (atom_valid),
    .atom_data     (atom_data),
    .atom_ready    (atom_ready),
    .test_ending   (test_ending),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .dct_buffer    (dct_buffer),
    .dct_count     (dct_count),
    .test_has_ended(test_has_ended),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUF_W-1:0] buffer;
    int               count;
  } frame_t;

  int errors = 0;
  int checks = 0;

  frame_t            sb[$];
  logic [ATOM_W-1:0] atoms[$];
  bit                outstanding;
  bit                pend;
  bit                ended;
  int                out_cnt;
  int                drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Oldest atom lands in the most significant occupied slot; unused upper slots are zero.
  function automatic frame_t make_frame();
    frame_t f;
    longint acc = 0;
    foreach (atoms[i]) acc = acc * 4 + longint'(atoms[i]);
    f.buffer = BUF_W'(acc);
    f.count  = atoms.size();
    return f;
  endfunction

  // Reference model: one update per cycle, sampled on the falling edge.
  initial begin
    bit fill;
    int exp_cnt;
    frame_t f;
    forever begin
      @(negedge clk);
      if (reset) begin
        atoms.delete();
        sb.delete();
        outstanding = 0;
        pend        = 0;
        ended       = 0;
        out_cnt     = 0;
        drops       = 0;
      end else begin
        fill    = !outstanding && !ended;
        exp_cnt = outstanding ? out_cnt : (ended ? 0 : atoms.size());
`ifdef NIOS2_OCI_DCT_DROP_EN
        check("atom_ready", 32'(atom_ready), 32'(1));
`else
        check("atom_ready", 32'(atom_ready), 32'(fill));
`endif
        check("frame_valid", 32'(frame_valid), 32'(outstanding));
        check("test_has_ended", 32'(test_has_ended), 32'(ended));
        check("dct_count", 32'(dct_count), 32'(exp_cnt));
        check("drop_count", 32'(drop_count), 32'(drops));
`ifdef NIOS2_OCI_DCT_DROP_EN
        if (atom_valid && !fill && drops < 65535) drops++;
`endif
        if (outstanding) begin
          if (test_ending) pend = 1;
          if (frame_ready) begin
            outstanding = 0;
            out_cnt     = 0;
            if (pend) ended = 1;
          end
        end else if (!ended) begin
          if (atom_valid) atoms.push_back(atom_data);
          if (test_ending) pend = 1;
          if (atoms.size() == int'(DEPTH) || (pend && atoms.size() > 0)) begin
            f = make_frame();
            sb.push_back(f);
            out_cnt = f.count;
            atoms.delete();
            outstanding = 1;
          end else if (pend) begin
            ended = 1;
          end
        end
      end
    end
  end

  // Monitor: compare each delivered frame against the oldest expected one.
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (!reset && frame_valid === 1'b1 && frame_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got buffer %0h count %0d expected no frame at %0t",
                   dct_buffer, dct_count, $time);
        end else begin
          f = sb.pop_front();
          check("frame_buffer", 32'(dct_buffer), 32'(f.buffer));
          check("frame_count", 32'(dct_count), 32'(f.count));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [ATOM_W-1:0] d, input logic te, input logic fr);
    @(posedge clk);
    #1;
    atom_valid  = v;
    atom_data   = d;
    test_ending = te;
    frame_ready = fr;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset       = 1'b1;
    atom_valid  = 1'b0;
    atom_data   = '0;
    test_ending = 1'b0;
    frame_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check(name, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    reset       = 1'b1;
    atom_valid  = 1'b0;
    atom_data   = '0;
    test_ending = 1'b0;
    frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back full frame of TAKEN atoms.
    for (int i = 0; i < 15; i++) step(1'b1, ATOM_TAKEN, 1'b0, 1'b1);
    drain("drain_full");

    // Short frame flushed by test_ending.
    step(1'b1, ATOM_INDIRECT, 1'b0, 1'b1);
    step(1'b1, ATOM_NOT_TAKEN, 1'b0, 1'b1);
    step(1'b1, ATOM_TAKEN, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    drain("drain_flush3");

    // Backpressure with atom_valid held.
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, ATOM_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, ATOM_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, ATOM_W'($urandom), 1'b0, 1'b1);
    drain("drain_backpressure");

    // test_ending coincident with the 15th accept.
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, ATOM_NOT_TAKEN, 1'b0, 1'b1);
    step(1'b1, ATOM_INDIRECT, 1'b1, 1'b1);
    drain("drain_end_on_full");

    // test_ending with nothing buffered.
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1);
    drain("drain_empty_end");

    // Reset in the middle of a partial frame.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, ATOM_W'($urandom), 1'b0, 1'b1);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // 20 atoms into a stalled sink.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, ATOM_W'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
`ifdef NIOS2_OCI_DCT_DROP_EN
    check("drop_count_20", 32'(drop_count), 32'(5));
`else
    check("drop_count_20", 32'(drop_count), 32'(0));
`endif
    drain("drain_stream20");

    // Random episodes.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        step(($urandom % 4) != 0, ATOM_W'($urandom), ($urandom % 60) == 0, ($urandom % 3) != 0);
      end
      drain("drain_random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
